// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } shift_seq_state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_bitcnt.sv
// Counter of enabled shifts in the current job.
// term flags the increment that completes the last shift of the word.
module shift_seq_bitcnt #(
   parameter int MSB   = 8,
   parameter int CNT_W = $clog2(MSB + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear has priority; otherwise count one per enabled shift.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign term = inc && (cnt_q == CNT_W'(MSB - 1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that serialises a parallel word into an external shift register,
// then reads the register back and returns it over a valid/ready port.
// Optional readback comparator enabled by defining SHIFT_SEQ_CHECK_EN.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int MSB   = 8,
   parameter int CNT_W = $clog2(MSB + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [MSB-1:0]   load_data,
   input  logic             load_dir,
   input  logic             hold,
   output logic             sr_d,
   output logic             sr_en,
   output logic             sr_dir,
   input  logic [MSB-1:0]   sr_out,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [MSB-1:0]   done_data,
   output logic             chk_err
);

   shift_seq_state_e state_q, state_d;
   logic [MSB-1:0]   word_q, word_d;
   logic             dir_q, dir_d;
   logic [MSB-1:0]   done_data_q, done_data_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_term;
   logic [MSB-1:0]   word_msb_first;
   logic [MSB-1:0]   word_lsb_first;

   shift_seq_bitcnt #(
      .MSB   (MSB),
      .CNT_W (CNT_W)
   ) u_bitcnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (bit_cnt),
      .term (cnt_term)
   );

   // The bit pointer is the shift count itself: shifting the word moves the next bit to a fixed tap.
   assign word_msb_first = word_q << bit_cnt;
   assign word_lsb_first = word_q >> bit_cnt;

   // Next-state, datapath capture and handshake/pin outputs.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      dir_d       = dir_q;
      done_data_d = done_data_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      load_ready  = 1'b0;
      done_valid  = 1'b0;
      busy        = 1'b1;
      sr_en       = 1'b0;
      sr_d        = 1'b0;
      case (state_q)
         IDLE: begin
            busy       = 1'b0;
            load_ready = 1'b1;
            if (load_valid) begin
               word_d  = load_data;
               dir_d   = load_dir;
               cnt_clr = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_en   = !hold;
            cnt_inc = !hold;
            sr_d    = (dir_q == DIR_RIGHT) ? word_lsb_first[0] : word_msb_first[MSB-1];
            if (cnt_term) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            done_data_d = sr_out;
            state_d     = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         dir_q       <= DIR_LEFT;
         done_data_q <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         dir_q       <= dir_d;
         done_data_q <= done_data_d;
      end
   end

   assign sr_dir    = dir_q;
   assign done_data = done_data_q;

`ifdef SHIFT_SEQ_CHECK_EN
   logic chk_err_q, chk_err_d;

   // Readback must equal the loaded word in either direction; flag captured with done_data.
   always_comb begin
      chk_err_d = chk_err_q;
      if (state_q == SETTLE) begin
         chk_err_d = (sr_out != word_q);
      end
   end

   // Mismatch flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err_q <= 1'b0;
      end else begin
         chk_err_q <= chk_err_d;
      end
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule
